// File: rtl/draw_rect_sync_pkg.sv
// Shared types and constants for the rectangle overlay pixel stage.
package draw_rect_sync_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;

    typedef logic [11:0] rgb_t;
    typedef logic [10:0] coord_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    // Inclusive span test done in 12 bits so that lo + len never wraps.
    function automatic logic in_span(input coord_t v, input coord_t lo, input logic [11:0] len);
        logic [11:0] w_lo;
        logic [11:0] w_hi;
        w_lo = {1'b0, lo};
        w_hi = w_lo + len - 12'd1;
        return ({1'b0, v} >= w_lo) && ({1'b0, v} <= w_hi);
    endfunction

endpackage

// File: rtl/draw_rect_sync_if.sv
// VGA pixel stream bundle: counters, syncs, blanks and colour.
interface vga_if;
    import draw_rect_sync_pkg::*;

    coord_t hcount;
    coord_t vcount;
    logic   hsync;
    logic   vsync;
    logic   hblnk;
    logic   vblnk;
    rgb_t   rgb;

    // Consumer side of the stream.
    modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    // Producer side of the stream.
    modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/draw_rect_sync.sv
// Overlays a solid rectangle on a VGA stream with one clock of latency.
// The rectangle position is double-buffered: a request is parked in a
// pending register and only becomes active at the rising edge of vblnk,
// so a visible frame never shows a half-moved rectangle.
module draw_rect_sync
    import draw_rect_sync_pkg::*;
#(
    parameter int     RECT_W     = 48,
    parameter int     RECT_H     = 64,
    parameter rgb_t   RECT_COLOR = 12'hF00,
    parameter coord_t X_INIT     = 11'd0,
    parameter coord_t Y_INIT     = 11'd0
) (
    input  logic   clk,
    input  logic   rst,
    vga_if.in      in,
    vga_if.out     out,
    input  coord_t pos_x,
    input  coord_t pos_y,
    input  logic   pos_valid,
    output logic   pos_ready,
    output logic   frame_start
);

    state_e r_state;
    state_e w_state_nxt;
    coord_t r_ax;
    coord_t r_ay;
    coord_t r_px;
    coord_t r_py;
    logic   r_vblnk_prev;
    logic   w_vblnk_rise;
    logic   w_xfer;
    logic   w_commit;
    logic   w_hit;
    rgb_t   w_rgb_nxt;

    assign pos_ready    = (r_state == ST_IDLE) && !rst;
    assign w_xfer       = pos_valid && pos_ready;
    assign w_vblnk_rise = in.vblnk && !r_vblnk_prev;

    // Hit test against the active position and choice of the next pixel colour.
    always_comb begin
        w_hit     = 1'b0;
        w_rgb_nxt = in.rgb;
        if (!in.hblnk && !in.vblnk) begin
            w_hit = in_span(in.hcount, r_ax, 12'(RECT_W)) &&
                    in_span(in.vcount, r_ay, 12'(RECT_H));
        end else begin
            w_hit = 1'b0;
        end
        if (w_hit) begin
            w_rgb_nxt = RECT_COLOR;
        end else begin
            w_rgb_nxt = in.rgb;
        end
    end

    // Next-state logic: a parked request commits only on the vblnk rising edge.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = ST_PENDING;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (w_vblnk_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_commit    = 1'b1;
                end else begin
                    w_state_nxt = ST_PENDING;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_commit    = 1'b0;
            end
        endcase
    end

    // Position buffers, FSM state and vblnk edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ax         <= X_INIT;
            r_ay         <= Y_INIT;
            r_px         <= 11'd0;
            r_py         <= 11'd0;
            r_vblnk_prev <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_vblnk_prev <= in.vblnk;
            if (w_xfer) begin
                r_px <= pos_x;
                r_py <= pos_y;
            end
            if (w_commit) begin
                r_ax <= r_px;
                r_ay <= r_py;
            end
        end
    end

    // One-clock stream pipeline; timing fields are copied, colour is overlaid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out.hcount  <= 11'd0;
            out.vcount  <= 11'd0;
            out.hsync   <= 1'b0;
            out.vsync   <= 1'b0;
            out.hblnk   <= 1'b0;
            out.vblnk   <= 1'b0;
            out.rgb     <= 12'h000;
            frame_start <= 1'b0;
        end else begin
            out.hcount  <= in.hcount;
            out.vcount  <= in.vcount;
            out.hsync   <= in.hsync;
            out.vsync   <= in.vsync;
            out.hblnk   <= in.hblnk;
            out.vblnk   <= in.vblnk;
            out.rgb     <= w_rgb_nxt;
            frame_start <= w_vblnk_rise;
        end
    end

endmodule
